// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding, default
// sizing and the conditional two's-complement helper.
package div_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultCntW  = $clog2(DefaultWidth);

    // Callers zero-extend into 32 bits and truncate back; the low WIDTH bits of the
    // 32-bit negation equal the WIDTH-bit two's complement.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, try the
// subtraction, keep it or restore.
module div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic             i_q_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_a_next,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    assign w_shifted = {i_a, i_q_msb};
    assign w_trial   = w_shifted - {1'b0, i_divisor};

    // Between steps A is always below the divisor, so WIDTH bits hold it exactly.
    always_comb begin
        o_q_bit  = ~w_trial[WIDTH];
        o_a_next = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or unsigned per
// operation, with valid/ready on both sides and divide-by-zero / overflow flags.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_dbz,
    output logic             out_ovf
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           r_state, w_state_next;
    logic [WIDTH-1:0] r_a, r_q, r_dvsr, r_quot, r_rem;
    logic [CntW-1:0]  r_cnt;
    logic             r_qsign, r_rsign, r_dbz, r_ovf;

    logic             w_accept, w_last, w_div_zero, w_ovf_in;
    logic             w_dvd_neg, w_dvs_neg, w_qbit;
    logic [WIDTH-1:0] w_dvd_abs, w_dvs_abs, w_a_next, w_q_next;

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == '0);

    assign w_dvd_neg  = in_signed && in_dividend[WIDTH-1];
    assign w_dvs_neg  = in_signed && in_divisor[WIDTH-1];
    assign w_dvd_abs  = WIDTH'(cond_neg(32'(in_dividend), w_dvd_neg));
    assign w_dvs_abs  = WIDTH'(cond_neg(32'(in_divisor), w_dvs_neg));
    assign w_div_zero = (in_divisor == '0);
    assign w_ovf_in   = in_signed && (in_dividend == {1'b1, {(WIDTH-1){1'b0}}})
                        && (in_divisor == '1);

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_a      (r_a),
        .i_q_msb  (r_q[WIDTH-1]),
        .i_divisor(r_dvsr),
        .o_a_next (w_a_next),
        .o_q_bit  (w_qbit)
    );

    assign w_q_next = {r_q[WIDTH-2:0], w_qbit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_accept) w_state_next = w_div_zero ? StDone : StCalc;
            StCalc:  if (w_last) w_state_next = StDone;
            StDone:  if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_q     <= '0;
            r_dvsr  <= '0;
            r_cnt   <= '0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_a     <= '0;
                        r_q     <= w_dvd_abs;
                        r_dvsr  <= w_dvs_abs;
                        r_cnt   <= CntW'(WIDTH - 1);
                        r_qsign <= w_dvd_neg ^ w_dvs_neg;
                        r_rsign <= w_dvd_neg;
                        r_dbz   <= w_div_zero;
                        r_ovf   <= w_ovf_in;
                        if (w_div_zero) begin
                            r_quot <= '1;
                            r_rem  <= in_dividend;
                        end
                    end
                end
                StCalc: begin
                    r_a   <= w_a_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - CntW'(1);
                    // Sign fix-up rides on the final step so DONE needs no extra cycle.
                    if (w_last) begin
                        r_quot <= WIDTH'(cond_neg(32'(w_q_next), r_qsign));
                        r_rem  <= WIDTH'(cond_neg(32'(w_a_next), r_rsign));
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_quotient  = r_quot;
    assign out_remainder = r_rem;
    assign out_dbz       = r_dbz;
    assign out_ovf       = r_ovf;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (WIDTH=8): directed corner cases, then a
// randomized signed/unsigned mix against an integer-arithmetic reference.
module tb_seq_restoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_dividend;
    logic [W-1:0] in_divisor;
    logic         in_signed;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_quotient;
    logic [W-1:0] out_remainder;
    logic         out_dbz;
    logic         out_ovf;

    seq_restoring_divider #(
        .WIDTH(W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .in_signed    (in_signed),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_remainder(out_remainder),
        .out_dbz      (out_dbz),
        .out_ovf      (out_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 0;
    bit   hold_ready = 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: C-style truncating division on plain integers.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s);
        exp_t e;
        int   sa, sb_, qi, ri;
        e.dbz = 0;
        e.ovf = 0;
        e.cyc = 0;
        if (b == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1;
        end else if (s) begin
            sa = int'($signed(a));
            sb_ = int'($signed(b));
            if (sa == -(1 << (W - 1)) && sb_ == -1) e.ovf = 1;
            qi  = sa / sb_;
            ri  = sa % sb_;
            e.q = W'(qi);
            e.r = W'(ri);
        end else begin
            e.q = W'(int'(a) / int'(b));
            e.r = W'(int'(a) % int'(b));
        end
        return e;
    endfunction

    // All stimulus tasks start and end at posedge+1.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        int   guard = 0;
        while (!in_ready) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 300) begin
                check("issue_wait_ready", 32'(in_ready), 32'd1);
                return;
            end
        end
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        in_signed   = s;
        @(posedge clk);
        #1;
        e     = model(a, b, s);
        e.cyc = cyc;
        sb.push_back(e);
        in_valid    = 1'b0;
        in_dividend = W'($urandom);
        in_divisor  = W'($urandom);
        in_signed   = 1'($urandom);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 || !in_ready) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 500) begin
                check("drain_timeout", 32'(sb.size()), 32'd0);
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(3) != 0) : hold_ready;
        end
    end

    // Monitor: checks each result on first appearance, then holds it bit-stable.
    initial begin
        exp_t         e;
        bit           active = 0;
        bit           want_idle = 0;
        logic [W-1:0] snap_q, snap_r;
        logic         snap_d, snap_o;
        forever begin
            @(negedge clk);
            if (rst) begin
                active    = 0;
                want_idle = 0;
            end else begin
                if (want_idle) begin
                    check("in_ready_after_xfer", 32'(in_ready), 32'd1);
                    check("valid_drop_after_xfer", 32'(out_valid), 32'd0);
                    want_idle = 0;
                end
                if (out_valid) begin
                    if (!active) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_result got q=%0h r=%0h expected none",
                                     out_quotient, out_remainder);
                        end else begin
                            e = sb.pop_front();
                            check("quotient", 32'(out_quotient), 32'(e.q));
                            check("remainder", 32'(out_remainder), 32'(e.r));
                            check("dbz", 32'(out_dbz), 32'(e.dbz));
                            check("ovf", 32'(out_ovf), 32'(e.ovf));
                            // Valid first visible after edge E+W (E itself for div-by-zero).
                            check("latency", 32'(cyc - e.cyc), e.dbz ? 32'd0 : 32'(W));
                        end
                        snap_q = out_quotient;
                        snap_r = out_remainder;
                        snap_d = out_dbz;
                        snap_o = out_ovf;
                        active = 1;
                    end else begin
                        check("hold_quotient", 32'(out_quotient), 32'(snap_q));
                        check("hold_remainder", 32'(out_remainder), 32'(snap_r));
                        check("hold_flags", {30'd0, out_dbz, out_ovf}, {30'd0, snap_d, snap_o});
                    end
                    check("busy_in_ready", 32'(in_ready), 32'd0);
                    if (out_ready) begin
                        active    = 0;
                        want_idle = 1;
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        in_signed   = 1'b0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", {14'd0, out_quotient, out_remainder, out_dbz, out_ovf}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        issue(8'd100, 8'd7, 1'b0);
        drain();
        issue(8'h9C, 8'h07, 1'b1);
        issue(8'd100, 8'hF9, 1'b1);
        issue(8'h9C, 8'h07, 1'b0);
        issue(8'd200, 8'd0, 1'b0);
        issue(8'h9C, 8'd0, 1'b1);
        issue(8'h80, 8'hFF, 1'b1);
        issue(8'h80, 8'h01, 1'b1);
        drain();

        // Backpressure with stray in_valid pulses while DONE.
        hold_ready = 0;
        @(posedge clk);
        #1;
        issue(8'h3C, 8'd5, 1'b0);
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        repeat (5) begin
            in_valid    = 1'($urandom);
            in_dividend = W'($urandom);
            in_divisor  = W'($urandom);
            in_signed   = 1'($urandom);
            @(posedge clk);
            #1;
            check("bp_still_valid", 32'(out_valid), 32'd1);
        end
        in_valid   = 1'b0;
        hold_ready = 1;
        drain();

        // Reset at the third CALC step abandons the operation.
        issue(8'h55, 8'd3, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_outputs", {14'd0, out_quotient, out_remainder, out_dbz, out_ovf}, 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        issue(8'd255, 8'd16, 1'b0);
        drain();

        rand_ready = 1;
        for (int n = 0; n < 3000; n++) begin
            logic [W-1:0] a, b;
            logic         s;
            a = W'($urandom);
            b = W'($urandom);
            s = 1'($urandom);
            case ($urandom_range(15))
                0:       b = '0;
                1:       begin a = 8'h80; b = 8'hFF; s = 1'b1; end
                2:       b = W'($urandom_range(2));
                default: ;
            endcase
            issue(a, b, s);
            repeat ($urandom_range(2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 0;
        hold_ready = 1;
        drain();
        repeat (20) @(posedge clk);
        #1;
        check("final_idle", 32'(out_valid), 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
